instr_mem_loader: RTL and testbench
===================================

# instr_mem_loader

Boot-time writer for the instruction memory: receives a framed byte stream, assembles big-endian 32-bit instruction words and writes them to consecutive word-aligned byte addresses (stride +4) starting at a base address. It sits between the external program/download interface and the instruction memory's write port, so the memory's read side sees the loaded program at the addresses the fetch stage later presents.

## Interface
- BASE_ADDR, 32'h0000_0000, byte address of the first written word; must be a multiple of 4
- WORDS, 64, instruction memory depth in 32-bit words; upper limit on the header count
- clk  input  1  system clock; all state changes on the rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle request to begin a new load
- byte_in  input  8  stream byte
- byte_valid  input  1  byte_in holds a valid byte
- byte_ready  output  1  loader accepts a byte this cycle; a transfer occurs when byte_valid and byte_ready are both high at a rising edge
- WE  output  1  one-cycle write strobe to instruction memory
- WA  output  32  write byte address
- WD  output  32  write data
- busy  output  1  load in progress
- done  output  1  last load completed successfully; held until the next start or reset
- err  output  1  last load rejected: header count exceeded WORDS; held until the next start or reset

## Operation
- Frame format: 2-byte word count N (MSB first), followed by 4·N data bytes, each word MSB first (byte 0 goes to WD[31:24]).
- States: IDLE, HDR_HI, HDR_LO, DATA, LAST, DONE, ERR.
- IDLE / DONE / ERR: byte_ready=0. start → HDR_HI; clears done and err; word index=0; byte counter=0.
- start while busy is ignored.
- HDR_HI: byte_ready=1. A transfer latches N[15:8] → HDR_LO.
- HDR_LO: byte_ready=1. A transfer latches N[7:0], then:
  - N=0 → DONE, no writes.
  - N>WORDS → ERR, no writes; remaining stream bytes are not consumed.
  - otherwise → DATA.
- DATA: byte_ready=1. Each transfer shifts the byte into the assembly register; the 2-bit byte counter increments.
  - On the 4th byte of a word: WD is loaded with the full word, WA = BASE_ADDR + 4·index, WE is set for one cycle, index increments, byte counter wraps to 0.
  - If that word was word N-1 → LAST, else stay in DATA.
- Byte acceptance continues during a WE cycle. The assembly register is separate from WD, so the stream never stalls.
- LAST: byte_ready=0 → DONE on the next edge.
- busy=1 in HDR_HI, HDR_LO, DATA and LAST; 0 otherwise.
- byte_valid while byte_ready=0: the byte is not consumed and has no effect.
- Counters: index is 16 bits; no address wrap occurs because N≤WORDS.

## Timing
- Reset values: byte_ready=0, WE=0, WA=BASE_ADDR, WD=0, busy=0, done=0, err=0. State is IDLE; counters and assembly register are cleared.
- Reset mid-load aborts immediately; a partial word is discarded and no WE is issued.
- start sampled at edge t → busy=1 and byte_ready=1 in cycle t+1.
- 4th byte of a word accepted at edge t → WE=1 with valid WA/WD during cycle t+1 only.
- WA and WD hold their values after WE drops, until the next write.
- Final word: WE in cycle t+1, done=1 and busy=0 from cycle t+2.
- Header making N=0 or N>WORDS accepted at edge t → done or err (respectively) =1 and busy=0 from cycle t+1.
- Maximum throughput: one byte per cycle, one word every 4 cycles.

## Test plan
- Reset check: hold rst_n=0 → WE=0, busy=0, done=0, err=0, WA=0, byte_ready=0. Release, wait 10 cycles → all outputs unchanged.
- Basic load: start, stream 00 02 12 34 56 78 9A BC DE F0 back-to-back → WE pulses with (WA=0, WD=12345678), then (WA=4, WD=9ABCDEF0), 4 cycles apart. done=1 two cycles after the last byte.
- Gapped stream: same frame with byte_valid low for 3 cycles between every byte → identical writes, one WE per word, no extra WE.
- Bounds: header 00 41 with WORDS=64 → err=1, no WE, byte_ready=0. Header 00 00 → done=1, no WE. Header 00 40 with 256 bytes → 64 writes, last WA=252.
- Reset mid-word: after 2 data bytes of word 1, pulse rst_n low → no WE, WA=BASE_ADDR. A new start then loads a full frame correctly from address 0.
- Restart: start while busy is ignored. start after done reloads: done clears the next cycle and a new frame writes again from BASE_ADDR.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Boot-time instruction memory loader.
// Accepts a framed byte stream (16-bit big-endian word count, then 4*N bytes),
// assembles big-endian 32-bit words and writes them to consecutive word
// addresses starting at BASE_ADDR.
module instr_mem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned WORDS     = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        WE,
  output logic [31:0] WA,
  output logic [31:0] WD,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] st_idle   = 3'd0;
  localparam logic [2:0] st_hdr_hi = 3'd1;
  localparam logic [2:0] st_hdr_lo = 3'd2;
  localparam logic [2:0] st_data   = 3'd3;
  localparam logic [2:0] st_last   = 3'd4;
  localparam logic [2:0] st_done   = 3'd5;
  localparam logic [2:0] st_err    = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [23:0] asm_q, asm_d;   // first three bytes of the word in flight
  logic        we_q, we_d;
  logic [31:0] wa_q, wa_d;
  logic [31:0] wd_q, wd_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        xfer;
  logic [15:0] hdr_n;

  assign byte_ready = (state_q == st_hdr_hi) || (state_q == st_hdr_lo) || (state_q == st_data);
  assign busy       = byte_ready || (state_q == st_last);
  assign xfer       = byte_valid && byte_ready;
  assign hdr_n      = {n_q[15:8], byte_in};

  assign WE   = we_q;
  assign WA   = wa_q;
  assign WD   = wd_q;
  assign done = done_q;
  assign err  = err_q;

  // Next-state logic: header parsing, word assembly and write issue.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    we_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    done_d  = done_q;
    err_d   = err_q;

    case (state_q)
      st_idle, st_done, st_err: begin
        if (start) begin
          state_d = st_hdr_hi;
          done_d  = 1'b0;
          err_d   = 1'b0;
          idx_d   = '0;
          bcnt_d  = '0;
        end
      end
      st_hdr_hi: begin
        if (xfer) begin
          n_d     = {byte_in, 8'h00};
          state_d = st_hdr_lo;
        end
      end
      st_hdr_lo: begin
        if (xfer) begin
          n_d = hdr_n;
          if (hdr_n == 16'd0) begin
            state_d = st_done;
            done_d  = 1'b1;
          end else if ({16'd0, hdr_n} > WORDS) begin
            state_d = st_err;
            err_d   = 1'b1;
          end else begin
            state_d = st_data;
          end
        end
      end
      st_data: begin
        if (xfer) begin
          asm_d  = {asm_q[15:0], byte_in};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            we_d  = 1'b1;
            wd_d  = {asm_q, byte_in};
            wa_d  = BASE_ADDR + {14'd0, idx_q, 2'b00};
            idx_d = idx_q + 16'd1;
            if (idx_q == n_q - 16'd1) begin
              state_d = st_last;
            end
          end
        end
      end
      st_last: begin
        state_d = st_done;
        done_d  = 1'b1;
      end
      default: state_d = st_idle;
    endcase
  end

  // State registers; reset aborts any load in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= st_idle;
      n_q     <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
      we_q    <= 1'b0;
      wa_q    <= BASE_ADDR;
      wd_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: a per-cycle vector table for the
// basic load plus directed sequences for gaps, bounds, reset and restart.
module tb_instr_mem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        WE;
  logic [31:0] WA;
  logic [31:0] WD;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [63:0] wq[$];   // {WA, WD} of every observed write

  instr_mem_loader #(
    .BASE_ADDR(32'h0000_0000),
    .WORDS    (64)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .WE        (WE),
    .WA        (WA),
    .WD        (WD),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (WE) wq.push_back({WA, WD});
  end

  typedef struct {
    logic        st;
    logic        bv;
    logic [7:0]  b;
    logic        rdy;
    logic        bsy;
    logic        dn;
    logic        er;
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
  } vec_t;

  vec_t vecs[13];
  logic [7:0] frame[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one byte and hold it until it transfers; returns at the negedge after.
  task automatic send(input logic [7:0] b, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      byte_valid = 1'b0;
      @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_in    = b;
    n = 0;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %h not accepted within 50 cycles", b);
    end else begin
      @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_frame(input int gap);
    for (int i = 0; i < 10; i++) send(frame[i], gap);
  endtask

  task automatic chk_frame_writes(input string tag);
    chk({tag, "_wcount"}, 32'(wq.size()), 32'd2);
    if (wq.size() == 2) begin
      chk({tag, "_wa0"}, wq[0][63:32], 32'h0000_0000);
      chk({tag, "_wd0"}, wq[0][31:0], 32'h1234_5678);
      chk({tag, "_wa1"}, wq[1][63:32], 32'h0000_0004);
      chk({tag, "_wd1"}, wq[1][31:0], 32'h9abc_def0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9a, 8'hbc, 8'hde, 8'hf0};
    //            st    bv    byte   rdy   bsy   dn    er    we    WA             WD
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 8'h12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[4]  = '{1'b0, 1'b1, 8'h34, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 8'h56, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[6]  = '{1'b0, 1'b1, 8'h78, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 8'h9a, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h1234_5678};
    vecs[8]  = '{1'b0, 1'b1, 8'hbc, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1234_5678};
    vecs[9]  = '{1'b0, 1'b1, 8'hde, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1234_5678};
    vecs[10] = '{1'b0, 1'b1, 8'hf0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1234_5678};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h4, 32'h9abc_def0};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h4, 32'h9abc_def0};

    // Reset state, during and after reset.
    rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    #12;
    chk("rst_ctl", {27'd0, byte_ready, busy, done, err, WE}, 32'd0);
    chk("rst_wa", WA, 32'h0);
    chk("rst_wd", WD, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_ctl", {27'd0, byte_ready, busy, done, err, WE}, 32'd0);
    chk("post_rst_wa", WA, 32'h0);
    chk("post_rst_wd", WD, 32'h0);

    // Basic back-to-back load, checked cycle by cycle.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      start      = vecs[i].st;
      byte_valid = vecs[i].bv;
      byte_in    = vecs[i].b;
      chk($sformatf("vec%0d_ctl", i), {27'd0, byte_ready, busy, done, err, WE},
          {27'd0, vecs[i].rdy, vecs[i].bsy, vecs[i].dn, vecs[i].er, vecs[i].we});
      chk($sformatf("vec%0d_wa", i), WA, vecs[i].wa);
      chk($sformatf("vec%0d_wd", i), WD, vecs[i].wd);
    end
    start = 1'b0; byte_valid = 1'b0;
    chk_frame_writes("basic");

    // Gapped stream: same frame, 3 idle cycles before every byte.
    wq.delete();
    do_start();
    send_frame(3);
    repeat (3) @(negedge clk);
    chk_frame_writes("gapped");
    chk("gapped_done", {31'd0, done}, 32'd1);

    // Header over the limit: err, no writes, further bytes not consumed.
    wq.delete();
    do_start();
    send(8'h00, 0);
    send(8'h41, 0);
    chk("over_ctl", {27'd0, byte_ready, busy, done, err, WE}, 32'b00010);
    byte_valid = 1'b1; byte_in = 8'h55;
    repeat (3) @(negedge clk);
    chk("over_hold", {27'd0, byte_ready, busy, done, err, WE}, 32'b00010);
    byte_valid = 1'b0;
    chk("over_nowrite", 32'(wq.size()), 32'd0);

    // Zero-length frame: err cleared by start, then done with no writes.
    do_start();
    chk("zero_errclr", {27'd0, byte_ready, busy, done, err, WE}, 32'b11000);
    send(8'h00, 0);
    send(8'h00, 0);
    chk("zero_ctl", {27'd0, byte_ready, busy, done, err, WE}, 32'b00100);
    chk("zero_nowrite", 32'(wq.size()), 32'd0);

    // Full-depth frame: 64 words, last at byte address 252.
    wq.delete();
    do_start();
    send(8'h00, 0);
    send(8'h40, 0);
    for (int i = 0; i < 256; i++) send(8'(i), 0);
    repeat (2) @(negedge clk);
    chk("full_wcount", 32'(wq.size()), 32'd64);
    bad = 0;
    for (int k = 0; k < wq.size(); k++) begin
      if (wq[k] !== {32'(4 * k), 8'(4 * k), 8'(4 * k + 1), 8'(4 * k + 2), 8'(4 * k + 3)}) bad++;
    end
    chk("full_words_bad", 32'(bad), 32'd0);
    if (wq.size() == 64) chk("full_last_wa", wq[63][63:32], 32'd252);
    chk("full_done", {27'd0, byte_ready, busy, done, err, WE}, 32'b00100);

    // Reset mid-word: partial word discarded, then a clean reload from base.
    do_start();
    for (int i = 0; i < 8; i++) send(frame[i], 0);
    wq.delete();
    rst_n = 1'b0;
    #1;
    chk("midrst_ctl", {27'd0, byte_ready, busy, done, err, WE}, 32'd0);
    chk("midrst_wa", WA, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_nowrite", 32'(wq.size()), 32'd0);
    do_start();
    send_frame(0);
    repeat (2) @(negedge clk);
    chk_frame_writes("reload");
    chk("reload_done", {31'd0, done}, 32'd1);

    // start while busy is ignored; start after done clears done and reloads.
    wq.delete();
    do_start();
    send(8'h00, 0); send(8'h01, 0); send(8'h12, 0); send(8'h34, 0);
    start = 1'b1;
    send(8'h56, 0);
    start = 1'b0;
    send(8'h78, 0);
    @(negedge clk);
    chk("busy_start_done", {31'd0, done}, 32'd1);
    chk("busy_start_wcount", 32'(wq.size()), 32'd1);
    if (wq.size() >= 1) chk("busy_start_w0", wq[0][31:0], 32'h1234_5678);
    do_start();
    chk("restart_ctl", {27'd0, byte_ready, busy, done, err, WE}, 32'b11000);
    send(8'h00, 0); send(8'h01, 0);
    send(8'hca, 0); send(8'hfe, 0); send(8'hba, 0); send(8'hbe, 0);
    repeat (2) @(negedge clk);
    chk("restart_wcount", 32'(wq.size()), 32'd2);
    if (wq.size() == 2) begin
      chk("restart_wa", wq[1][63:32], 32'h0);
      chk("restart_wd", wq[1][31:0], 32'hcafe_babe);
    end
    chk("restart_done", {31'd0, done}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
